// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets,
// CON bit positions, FSM state encodings and the CON packing helper.
package uart_defs;

   // Byte offsets of the three registers relative to BASE_ADDR
   localparam logic [31:0] OFF_TX_DATA = 32'h0000_0000;
   localparam logic [31:0] OFF_RX_DATA = 32'h0000_0004;
   localparam logic [31:0] OFF_CON     = 32'h0000_0008;

   // Bit positions inside the CON register
   localparam int CON_TX_BUSY   = 0;
   localparam int CON_RX_VALID  = 1;
   localparam int CON_OVERRUN   = 2;
   localparam int CON_TX_DONE   = 3;
   localparam int CON_IRQ_EN    = 4;
   localparam int CON_FRAME_ERR = 5;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_t;

   // Assemble the CON read word from the individual status bits
   function automatic logic [31:0] pack_con(
      input logic frame_err,
      input logic irq_en,
      input logic tx_done,
      input logic overrun,
      input logic rx_valid,
      input logic tx_busy
   );
      logic [31:0] w;
      w = 32'h0000_0000;
      w[CON_FRAME_ERR] = frame_err;
      w[CON_IRQ_EN]    = irq_en;
      w[CON_TX_DONE]   = tx_done;
      w[CON_OVERRUN]   = overrun;
      w[CON_RX_VALID]  = rx_valid;
      w[CON_TX_BUSY]   = tx_busy;
      return w;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// 16x-oversample tick generator: a free-running 0..DIV-1 counter that
// pulses tick for one clock per period. Shared by the RX and TX FSMs.
module uart_baud_gen #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] count;

   // Wrap the counter at DIV-1 and register the tick pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
         tick  <= 1'b0;
      end else begin
         tick <= (count == LAST);
         if (count == LAST) begin
            count <= '0;
         end else begin
            count <= count + CW'(1);
         end
      end
   end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART peripheral: TX_DATA / RX_DATA / CON registers,
// combinational load data, 16x-oversampled receiver, transmitter and a
// registered level interrupt.
module uart_mmio
   import uart_defs::*;
#(
   parameter int          CLK_FREQ  = 100_000_000,
   parameter int          BAUD      = 9600,
   parameter logic [31:0] BASE_ADDR = 32'h4000_0018
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rd,
   input  logic        wr,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   input  logic        rx,
   output logic        tx,
   output logic        irq
);
   localparam int DIV = CLK_FREQ / (BAUD * 16);
   localparam logic [31:0] TX_ADDR  = BASE_ADDR + OFF_TX_DATA;
   localparam logic [31:0] RX_ADDR  = BASE_ADDR + OFF_RX_DATA;
   localparam logic [31:0] CON_ADDR = BASE_ADDR + OFF_CON;

   logic tick;
   logic sel_tx, sel_rx, sel_con;
   logic rd_rx, rd_con, wr_con;

   logic rx_meta, rx_s;
   rx_state_t rx_state, rx_next;
   logic [3:0] rx_cnt, rx_cnt_next;
   logic [2:0] rx_bit, rx_bit_next;
   logic [7:0] rx_shift, rx_shift_next;
   logic rx_done, rx_ferr;

   tx_state_t tx_state, tx_next;
   logic [3:0] tx_cnt, tx_cnt_next;
   logic [2:0] tx_bit, tx_bit_next;
   logic [7:0] tx_shift, tx_shift_next;
   logic tx_line_next, tx_fin, tx_busy;

   logic [7:0] rx_byte;
   logic rx_valid, overrun, frame_err, tx_done, irq_en;

   logic unused_bits;
   assign unused_bits = ^{wdata[31:8], addr[1:0]};

   uart_baud_gen #(.DIV(DIV)) u_baud (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   assign sel_tx  = (addr[31:2] == TX_ADDR[31:2]);
   assign sel_rx  = (addr[31:2] == RX_ADDR[31:2]);
   assign sel_con = (addr[31:2] == CON_ADDR[31:2]);
   assign rd_rx   = rd & sel_rx;
   assign rd_con  = rd & sel_con;
   assign wr_con  = wr & sel_con;
   assign tx_busy = (tx_state != TX_IDLE);

   // Two-flop synchronizer for the asynchronous serial input (idles high)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   // RX state register and datapath
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_state <= RX_IDLE;
         rx_cnt   <= 4'd0;
         rx_bit   <= 3'd0;
         rx_shift <= 8'h00;
      end else begin
         rx_state <= rx_next;
         rx_cnt   <= rx_cnt_next;
         rx_bit   <= rx_bit_next;
         rx_shift <= rx_shift_next;
      end
   end

   // RX next-state: mid-bit sampling at tick 8 of the start bit, then every 16 ticks
   always_comb begin
      rx_next       = rx_state;
      rx_cnt_next   = rx_cnt;
      rx_bit_next   = rx_bit;
      rx_shift_next = rx_shift;
      rx_done       = 1'b0;
      rx_ferr       = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            if (!rx_s) begin
               rx_next     = RX_START;
               rx_cnt_next = 4'd0;
            end else begin
               rx_next = RX_IDLE;
            end
         end
         RX_START: begin
            if (tick && (rx_cnt == 4'd7)) begin
               rx_cnt_next = 4'd0;
               rx_bit_next = 3'd0;
               rx_next     = rx_s ? RX_IDLE : RX_DATA;
            end else if (tick) begin
               rx_cnt_next = rx_cnt + 4'd1;
            end else begin
               rx_cnt_next = rx_cnt;
            end
         end
         RX_DATA: begin
            if (tick && (rx_cnt == 4'd15)) begin
               rx_cnt_next   = 4'd0;
               rx_shift_next = {rx_s, rx_shift[7:1]};
               if (rx_bit == 3'd7) begin
                  rx_next = RX_STOP;
               end else begin
                  rx_bit_next = rx_bit + 3'd1;
               end
            end else if (tick) begin
               rx_cnt_next = rx_cnt + 4'd1;
            end else begin
               rx_cnt_next = rx_cnt;
            end
         end
         RX_STOP: begin
            if (tick && (rx_cnt == 4'd15)) begin
               rx_cnt_next = 4'd0;
               rx_next     = RX_IDLE;
               if (rx_s) begin
                  rx_done = 1'b1;
               end else begin
                  rx_ferr = 1'b1;
               end
            end else if (tick) begin
               rx_cnt_next = rx_cnt + 4'd1;
            end else begin
               rx_cnt_next = rx_cnt;
            end
         end
         default: begin
            rx_next = RX_IDLE;
         end
      endcase
   end

   // TX state register; the async reset returns the line high immediately
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= 4'd0;
         tx_bit   <= 3'd0;
         tx_shift <= 8'h00;
         tx       <= 1'b1;
      end else begin
         tx_state <= tx_next;
         tx_cnt   <= tx_cnt_next;
         tx_bit   <= tx_bit_next;
         tx_shift <= tx_shift_next;
         tx       <= tx_line_next;
      end
   end

   // TX next-state: start bit, 8 data bits LSB first, stop bit, 16 ticks each
   always_comb begin
      tx_next       = tx_state;
      tx_cnt_next   = tx_cnt;
      tx_bit_next   = tx_bit;
      tx_shift_next = tx_shift;
      tx_line_next  = tx;
      tx_fin        = 1'b0;
      case (tx_state)
         TX_IDLE: begin
            if (wr && sel_tx) begin
               tx_next       = TX_START;
               tx_cnt_next   = 4'd0;
               tx_shift_next = wdata[7:0];
               tx_line_next  = 1'b0;
            end else begin
               tx_line_next = 1'b1;
            end
         end
         TX_START: begin
            if (tick && (tx_cnt == 4'd15)) begin
               tx_next      = TX_DATA;
               tx_cnt_next  = 4'd0;
               tx_bit_next  = 3'd0;
               tx_line_next = tx_shift[0];
            end else if (tick) begin
               tx_cnt_next = tx_cnt + 4'd1;
            end else begin
               tx_cnt_next = tx_cnt;
            end
         end
         TX_DATA: begin
            if (tick && (tx_cnt == 4'd15)) begin
               tx_cnt_next = 4'd0;
               if (tx_bit == 3'd7) begin
                  tx_next      = TX_STOP;
                  tx_line_next = 1'b1;
               end else begin
                  tx_bit_next   = tx_bit + 3'd1;
                  tx_shift_next = {1'b0, tx_shift[7:1]};
                  tx_line_next  = tx_shift[1];
               end
            end else if (tick) begin
               tx_cnt_next = tx_cnt + 4'd1;
            end else begin
               tx_cnt_next = tx_cnt;
            end
         end
         TX_STOP: begin
            if (tick && (tx_cnt == 4'd15)) begin
               tx_next      = TX_IDLE;
               tx_cnt_next  = 4'd0;
               tx_line_next = 1'b1;
               tx_fin       = 1'b1;
            end else if (tick) begin
               tx_cnt_next = tx_cnt + 4'd1;
            end else begin
               tx_cnt_next = tx_cnt;
            end
         end
         default: begin
            tx_next      = TX_IDLE;
            tx_line_next = 1'b1;
         end
      endcase
   end

   // Status flags: hardware set events win over read-to-clear side effects
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_byte   <= 8'h00;
         rx_valid  <= 1'b0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
         tx_done   <= 1'b0;
         irq_en    <= 1'b0;
         irq       <= 1'b0;
      end else begin
         if (rx_done) begin
            rx_byte  <= rx_shift;
            rx_valid <= 1'b1;
         end else if (rd_rx) begin
            rx_valid <= 1'b0;
         end else begin
            rx_valid <= rx_valid;
         end
         overrun   <= (rx_done & rx_valid & ~rd_rx) | (overrun & ~rd_con);
         frame_err <= rx_ferr | (frame_err & ~rd_con);
         tx_done   <= tx_fin | (tx_done & ~rd_con);
         if (wr_con) begin
            irq_en <= wdata[4];
         end else begin
            irq_en <= irq_en;
         end
         irq <= irq_en & (rx_valid | tx_done);
      end
   end

   // Combinational load data; zero when not reading a mapped register
   always_comb begin
      rdata = 32'h0000_0000;
      if (rd && sel_rx) begin
         rdata = {24'h00_0000, rx_byte};
      end else if (rd && sel_con) begin
         rdata = pack_con(frame_err, irq_en, tx_done, overrun, rx_valid, tx_busy);
      end else begin
         rdata = 32'h0000_0000;
      end
   end

endmodule
